// File: rtl/band_energy_extractor_if.sv
// rtl/band_energy_extractor_if.sv - stream interface of the band energy extractor
//
// Purpose: bundles the magnitude input stream and the feature output stream
//          of band_energy_extractor.
// Signals:
//   mag_data_in        16  unsigned FFT bin magnitude
//   mag_valid_in        1  bin valid
//   mag_last_in         1  final bin of frame (qualified by mag_valid_in)
//   feature_data_out   16  signed feature value
//   feature_valid_out   1  feature valid
//   feature_last_out    1  high with the final feature of a vector
//   dropped_frames_out  8  saturating count of discarded frames
// Modports: master = magnitude source / feature sink, slave = extractor.

interface band_energy_extractor_if;
   logic [15:0] mag_data_in;
   logic        mag_valid_in;
   logic        mag_last_in;
   logic [15:0] feature_data_out;
   logic        feature_valid_out;
   logic        feature_last_out;
   logic [7:0]  dropped_frames_out;

   modport master (
      output mag_data_in, mag_valid_in, mag_last_in,
      input  feature_data_out, feature_valid_out, feature_last_out, dropped_frames_out
   );

   modport slave (
      input  mag_data_in, mag_valid_in, mag_last_in,
      output feature_data_out, feature_valid_out, feature_last_out, dropped_frames_out
   );
endinterface

// File: rtl/band_energy_extractor.sv
// rtl/band_energy_extractor.sv - per-band and total energy feature extractor
//
// Purpose: accumulates one FFT magnitude frame (one bin per cycle) into a
//          loudness accumulator and per-band accumulators, then streams a
//          NUM_FEATURES_OUT-entry feature vector, one feature per cycle.
//          Feature 0 = loudness, features 1.. = band energies.
// Ports:
//   clk_in   system clock
//   rst_in   synchronous active-high reset
//   bus      band_energy_extractor_if.slave (magnitude in, features out,
//            dropped frame counter)
// Build option: BAND_LOG_COMPRESS_EN selects log2-compressed features with
//               one extra output pipeline stage; undefined selects linear
//               shift-and-saturate output.

module band_energy_extractor #(
   parameter int NUM_FEATURES_OUT = 16,
   parameter int NUM_BINS         = 512,
   parameter int BAND_SHIFT       = 5,
   parameter int OUT_SHIFT        = 4
) (
   input  logic clk_in,
   input  logic rst_in,
   band_energy_extractor_if.slave bus
);

   localparam int IDX_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam int FEAT_W = (NUM_FEATURES_OUT > 1) ? $clog2(NUM_FEATURES_OUT) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BINS - 1);
   localparam logic [FEAT_W-1:0] LAST_FEAT = FEAT_W'(NUM_FEATURES_OUT - 1);

   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_EMIT  = 2'd1;
   localparam logic [1:0] ST_SKIP  = 2'd2;

   logic [1:0]        state;
   logic [IDX_W-1:0]  bin_idx;
   logic              idx_held;   // frame ran past its last bin; extra bins are ignored
   logic              in_frame;   // a frame started while emitting; it will be skipped
   logic [FEAT_W-1:0] emit_cnt;
   logic [7:0]        dropped;
   logic [31:0]       acc [NUM_FEATURES_OUT];

`ifdef BAND_LOG_COMPRESS_EN
   logic [31:0]       emit_data;  // raw accumulator, compressed one stage later
   logic [15:0]       feat_data;
   logic              feat_valid;
   logic              feat_last;
`else
   logic [15:0]       emit_data;
`endif
   logic              emit_valid;
   logic              emit_last;

   logic              bin_valid;
   logic              bin_last;
   logic [31:0]       mag32;
   logic [31:0]       band;
   logic              band_hit;
   logic [FEAT_W-1:0] band_sel;
   logic [31:0]       emit_raw;
   logic              in_frame_nx;
   logic              drop_evt;

`ifdef BAND_LOG_COMPRESS_EN
   // {0, leading-one position, 10 bits below the leading one}
   function automatic logic [15:0] log_feature(input logic [31:0] a);
      logic [4:0]  p;
      logic [31:0] norm;
      p = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (a[i]) p = 5'(i);
      end
      // Normalise so the leading one sits at bit 31; short values pad with zeros.
      norm = a << (5'd31 - p);
      if (a == 32'd0) return 16'd0;
      return {1'b0, p, 10'(norm >> 21)};
   endfunction
`else
   function automatic logic [15:0] lin_feature(input logic [31:0] a);
      logic [31:0] s;
      s = a >> OUT_SHIFT;
      return (s > 32'd32767) ? 16'h7FFF : 16'(s);
   endfunction
`endif

   always_comb begin
      bin_valid   = bus.mag_valid_in;
      bin_last    = bus.mag_valid_in && bus.mag_last_in;
      mag32       = {16'd0, bus.mag_data_in};
      band        = 32'(bin_idx) >> BAND_SHIFT;
      band_hit    = (band >= 32'd1) && (band < 32'(NUM_FEATURES_OUT));
      band_sel    = band[FEAT_W-1:0];
      emit_raw    = acc[emit_cnt];
      in_frame_nx = in_frame;
      drop_evt    = 1'b0;
      case (state)
         ST_EMIT: begin
            // Bins arriving while emitting belong to a frame we cannot take.
            if (bin_valid) begin
               if (bus.mag_last_in) begin
                  in_frame_nx = 1'b0;
                  drop_evt    = 1'b1;
               end else begin
                  in_frame_nx = 1'b1;
               end
            end
         end
         ST_SKIP: begin
            if (bin_last) begin
               in_frame_nx = 1'b0;
               drop_evt    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= ST_ACCUM;
         bin_idx    <= '0;
         idx_held   <= 1'b0;
         in_frame   <= 1'b0;
         emit_cnt   <= '0;
         dropped    <= 8'd0;
         emit_data  <= '0;
         emit_valid <= 1'b0;
         emit_last  <= 1'b0;
         for (int i = 0; i < NUM_FEATURES_OUT; i++) acc[i] <= 32'd0;
      end else begin
         emit_valid <= 1'b0;
         emit_last  <= 1'b0;
         in_frame   <= in_frame_nx;
         if (drop_evt && (dropped != 8'hFF)) dropped <= dropped + 8'd1;

         case (state)
            ST_ACCUM: begin
               if (bin_valid) begin
                  if (!idx_held) begin
                     acc[0] <= acc[0] + mag32;
                     // band_hit excludes band 0, so this never collides with acc[0]
                     if (band_hit) acc[band_sel] <= acc[band_sel] + mag32;
                  end
                  if (bus.mag_last_in) begin
                     bin_idx  <= '0;
                     idx_held <= 1'b0;
                     emit_cnt <= '0;
                     state    <= ST_EMIT;
                  end else if (bin_idx == LAST_IDX) begin
                     idx_held <= 1'b1;
                  end else begin
                     bin_idx <= bin_idx + IDX_W'(1);
                  end
               end
            end
            ST_EMIT: begin
               emit_valid <= 1'b1;
               emit_last  <= (emit_cnt == LAST_FEAT);
`ifdef BAND_LOG_COMPRESS_EN
               emit_data  <= emit_raw;
`else
               emit_data  <= lin_feature(emit_raw);
`endif
               // Read-and-clear leaves the accumulator ready for the next frame.
               acc[emit_cnt] <= 32'd0;
               if (emit_cnt == LAST_FEAT) begin
                  state <= in_frame_nx ? ST_SKIP : ST_ACCUM;
               end else begin
                  emit_cnt <= emit_cnt + FEAT_W'(1);
               end
            end
            ST_SKIP: begin
               if (bin_last) state <= ST_ACCUM;
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end

`ifdef BAND_LOG_COMPRESS_EN
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         feat_data  <= 16'd0;
         feat_valid <= 1'b0;
         feat_last  <= 1'b0;
      end else begin
         feat_data  <= log_feature(emit_data);
         feat_valid <= emit_valid;
         feat_last  <= emit_last;
      end
   end

   assign bus.feature_data_out  = feat_data;
   assign bus.feature_valid_out = feat_valid;
   assign bus.feature_last_out  = feat_last;
`else
   assign bus.feature_data_out  = emit_data;
   assign bus.feature_valid_out = emit_valid;
   assign bus.feature_last_out  = emit_last;
`endif
   assign bus.dropped_frames_out = dropped;

endmodule

// File: tb/tb_band_energy_extractor.sv
// tb/tb_band_energy_extractor.sv - randomized self-checking bench for band_energy_extractor

module tb_band_energy_extractor;
   localparam int NF = 16;
   localparam int NB = 512;
   localparam int BS = 5;
   localparam int OS = 4;
`ifdef BAND_LOG_COMPRESS_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   band_energy_extractor_if bus ();

   band_energy_extractor #(
      .NUM_FEATURES_OUT(NF),
      .NUM_BINS(NB),
      .BAND_SHIFT(BS),
      .OUT_SHIFT(OS)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .bus(bus)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int                frame_mag [NB+8];
   int                exp_t [$];
   logic [NF*16-1:0]  exp_v [$];
   logic [NF*16-1:0]  mon_vec;
   int                mon_k = 0;
   bit                mon_en = 1'b0;
   int                last_acc_t = -1000;
   int                drop_model = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  tag, obs, obs, exp, exp, cyc);
      end
   endtask

   function automatic logic [15:0] xform(input longint a);
`ifdef BAND_LOG_COMPRESS_EN
      int     p;
      longint m;
      if (a == 0) return 16'd0;
      p = 0;
      while ((longint'(1) << (p + 1)) <= a) p++;
      m = ((a - (longint'(1) << p)) * 1024) >> p;
      return {1'b0, 5'(p), 10'(m)};
`else
      longint s;
      s = a >> OS;
      return (s > 32767) ? 16'h7FFF : 16'(s);
`endif
   endfunction

   function automatic logic [NF*16-1:0] model_vec(input int len);
      longint           e [NF];
      logic [NF*16-1:0] v;
      int               b;
      for (int k = 0; k < NF; k++) e[k] = 0;
      for (int i = 0; i < len && i < NB; i++) begin
         e[0] += frame_mag[i];
         b = i / (1 << BS);
         if (b >= 1 && b < NF) e[b] += frame_mag[i];
      end
      for (int k = 0; k < NF; k++) v[k*16 +: 16] = xform(e[k]);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.mag_valid_in = 1'b0;
      bus.mag_data_in  = 16'($urandom);
      bus.mag_last_in  = 1'($urandom);
   endtask

   task automatic fill(input int mode, input int val);
      for (int i = 0; i < NB + 8; i++) begin
         case (mode)
            0:       frame_mag[i] = val;
            1:       frame_mag[i] = $urandom_range(65535);
            default: frame_mag[i] = $urandom_range(255);
         endcase
      end
   endtask

   task automatic send_frame(input int len, input int gap_pct, output int first_c, output int last_c);
      first_c = cyc;
      last_c  = cyc;
      for (int i = 0; i < len; i++) begin
         if (i > 0) begin
            while ($urandom_range(99) < gap_pct) begin
               drive_idle();
               step();
            end
         end
         bus.mag_valid_in = 1'b1;
         bus.mag_data_in  = 16'(frame_mag[i]);
         bus.mag_last_in  = (i == len - 1);
         if (i == 0) first_c = cyc;
         if (i == len - 1) last_c = cyc;
         step();
      end
      drive_idle();
   endtask

   // A frame is taken only if its first bin arrives after the previous
   // accepted frame's 16-cycle emission window; otherwise it is dropped.
   task automatic do_frame(input int len, input int gap_pct, input int pre_gap);
      int f, l;
      repeat (pre_gap) begin
         drive_idle();
         step();
      end
      send_frame(len, gap_pct, f, l);
      if (f > last_acc_t + NF) begin
         exp_t.push_back(l);
         exp_v.push_back(model_vec(len));
         last_acc_t = l;
      end else begin
         drop_model++;
      end
   endtask

   task automatic settle_check_dropped(input string tag);
      repeat (LAT + NF + 4) step();
      check(tag, bus.dropped_frames_out, (drop_model > 255) ? 255 : drop_model);
   endtask

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (bus.feature_valid_out) begin
            if (exp_t.size() == 0) begin
               check("unexpected_valid", bus.feature_valid_out, 0);
            end else begin
               mon_vec = exp_v[0];
               check("feat_data", bus.feature_data_out, mon_vec[mon_k*16 +: 16]);
               check("feat_cycle", cyc, exp_t[0] + LAT + mon_k);
               check("feat_last", bus.feature_last_out, (mon_k == NF - 1));
               if (mon_k == NF - 1) begin
                  void'(exp_t.pop_front());
                  void'(exp_v.pop_front());
                  mon_k = 0;
               end else begin
                  mon_k++;
               end
            end
         end else if (bus.feature_last_out) begin
            check("stray_last", bus.feature_last_out, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int               f, l, len, mode;
      logic [NF*16-1:0] v;
      bit               ev;

      drive_idle();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      check("reset_valid", bus.feature_valid_out, 0);
      check("reset_last", bus.feature_last_out, 0);
      check("reset_data", bus.feature_data_out, 0);
      check("reset_dropped", bus.dropped_frames_out, 0);
      mon_en = 1'b1;

      // full frames with flat, saturating and band-localised content
      fill(0, 16);
      do_frame(NB, 0, 0);
      fill(0, 65535);
      do_frame(NB, 0, 0);
      for (int i = 0; i < NB + 8; i++) frame_mag[i] = (i >= 32 && i < 64) ? 100 : 0;
      do_frame(NB, 0, 0);
      for (int i = 0; i < NB + 8; i++) frame_mag[i] = (i < 32) ? 100 : 0;
      do_frame(NB, 0, 0);
      settle_check_dropped("dropped_after_basic");

      // frame starting during emission is dropped; following frame is clean
      fill(0, 16);
      do_frame(NB, 0, 0);
      fill(1, 0);
      do_frame(NB, 0, 4);
      fill(0, 7);
      do_frame(NB, 0, 0);
      settle_check_dropped("dropped_overlap");

      // first bin on the final emit cycle vs. the first accumulate cycle
      fill(2, 0);
      do_frame(20, 0, 20);
      do_frame(10, 0, 15);
      do_frame(20, 0, 0);
      do_frame(30, 0, 16);
      // single-bin frames, including one whose only bin lands in emission
      do_frame(1, 0, 20);
      do_frame(1, 0, 3);
      settle_check_dropped("dropped_edges");

      // reset in the middle of emission
      mon_en = 1'b0;
      fill(0, 8);
      send_frame(40, 0, f, l);
      v = model_vec(40);
      for (int c = l + 1; c <= l + 6; c++) begin
         ev = (c >= l + LAT);
         check("rst_frame_valid", bus.feature_valid_out, ev);
         if (ev) check("rst_frame_data", bus.feature_data_out, v[(c - l - LAT)*16 +: 16]);
         if (c == l + 6) rst = 1'b1;
         step();
      end
      check("abort_valid", bus.feature_valid_out, 0);
      check("abort_last", bus.feature_last_out, 0);
      check("abort_dropped", bus.dropped_frames_out, 0);
      rst = 1'b0;
      drop_model = 0;
      last_acc_t = -1000;
      mon_en = 1'b1;
      fill(1, 0);
      do_frame(NB, 10, 2);
      settle_check_dropped("dropped_after_abort");

      // randomized frames: length, content, valid gaps and inter-frame spacing
      repeat (24) begin
         mode = $urandom_range(2);
         fill(mode, ($urandom_range(3) == 0) ? 65535 : $urandom_range(65535));
         case ($urandom_range(9))
            0, 1, 2, 3, 4: len = $urandom_range(80, 1);
            5, 6, 7:       len = NB;
            default:       len = NB + $urandom_range(4, 1);
         endcase
         do_frame(len, $urandom_range(30), $urandom_range(24));
      end
      settle_check_dropped("dropped_random");

      // drive the dropped counter into saturation
      repeat (260) begin
         fill(2, 0);
         do_frame(1, 0, NF);
         do_frame(1, 0, 2);
      end
      settle_check_dropped("dropped_saturated");

      check("pending_vectors", exp_t.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
